// File: rtl/id_ex_skid_stage_pkg.sv
// Shared definitions for the generic pipeline-stage register (package pipe_pkg).
// Holds the occupancy state type, ID/EX control-bit positions and default field widths.
package pipe_pkg;

    localparam int CTRL_W_DEF   = 8;
    localparam int DATA_W_DEF   = 32;
    localparam int NUM_DATA_DEF = 4;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_ADDR_DEF = 3;

    // Bit positions inside the control bundle when the stage sits between ID and EX
    localparam int ALUOP_HI = 7;
    localparam int ALUOP_LO = 6;
    localparam int ALUSRC   = 5;
    localparam int REGWRITE = 4;
    localparam int MEMTOREG = 3;
    localparam int MEMREAD  = 2;
    localparam int MEMWRITE = 1;
    localparam int BRANCH   = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    function automatic int entry_width(input int ctrl_w, input int data_bits, input int addr_bits);
        return ctrl_w + data_bits + addr_bits;
    endfunction

endpackage

// File: rtl/id_ex_skid_stage_entry_reg.sv
// pipe_entry_reg: one resettable entry register with load enable.
// Clear zeroes only the low CLR_W bits (the control field) so data/addresses keep their last value.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int W     = 8,
    parameter int CLR_W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ld_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] entry_q;

    // Entry storage: clear beats load so a flushed cycle never captures new control bits
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            entry_q <= {W{1'b0}};
        end else if (clr_i) begin
            entry_q[CLR_W-1:0] <= {CLR_W{1'b0}};
        end else if (ld_i) begin
            entry_q <= d_i;
        end else begin
            entry_q <= entry_q;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage: valid/ready pipeline register with a 2-entry skid and flush-to-bubble.
// Optional macro PIPE_STAGE_STATS_EN adds stall_cnt_o / bubble_cnt_o counters.
module id_ex_skid_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = CTRL_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_DATA = NUM_DATA_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_ADDR = NUM_ADDR_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [CTRL_W-1:0]            ctrl_i,
    input  logic [NUM_DATA*DATA_W-1:0]   data_i,
    input  logic [NUM_ADDR*ADDR_W-1:0]   addr_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [CTRL_W-1:0]            ctrl_o,
    output logic [NUM_DATA*DATA_W-1:0]   data_o,
`ifdef PIPE_STAGE_STATS_EN
    output logic [NUM_ADDR*ADDR_W-1:0]   addr_o,
    output logic [31:0]                  stall_cnt_o,
    output logic [31:0]                  bubble_cnt_o
`else
    output logic [NUM_ADDR*ADDR_W-1:0]   addr_o
`endif
);

    localparam int DW = NUM_DATA * DATA_W;
    localparam int AW = NUM_ADDR * ADDR_W;
    localparam int EW = entry_width(CTRL_W, DW, AW);

    stage_state_e state_q, state_d;
    logic         out_valid_q;
    logic         in_ready_q;
    logic         accept_s;
    logic         xfer_s;
    logic         main_ld_s;
    logic         main_sel_skid_s;
    logic         skid_ld_s;
    logic         clr_s;
    logic [EW-1:0] in_bus_s;
    logic [EW-1:0] main_d_s;
    logic [EW-1:0] main_q;
    logic [EW-1:0] skid_q;

    assign in_bus_s = {addr_i, data_i, ctrl_i};
    assign accept_s = in_valid_i & in_ready_q;
    assign xfer_s   = out_valid_q & out_ready_i;
    assign main_d_s = main_sel_skid_s ? skid_q : in_bus_s;

    // Occupancy next-state and register-load selection; flush overrides everything
    always_comb begin
        state_d         = state_q;
        main_ld_s       = 1'b0;
        main_sel_skid_s = 1'b0;
        skid_ld_s       = 1'b0;
        clr_s           = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
            clr_s   = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_s) begin
                        state_d   = ONE;
                        main_ld_s = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && xfer_s) begin
                        state_d   = ONE;
                        main_ld_s = 1'b1;
                    end else if (accept_s) begin
                        state_d   = FULL;
                        skid_ld_s = 1'b1;
                    end else if (xfer_s) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                FULL: begin
                    if (xfer_s) begin
                        state_d         = ONE;
                        main_ld_s       = 1'b1;
                        main_sel_skid_s = 1'b1;
                    end else begin
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State plus registered handshake flags, derived from the next state
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != EMPTY);
            in_ready_q  <= (state_d != FULL);
        end
    end

    pipe_entry_reg #(.W(EW), .CLR_W(CTRL_W)) u_main (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ld_i  (main_ld_s),
        .clr_i (clr_s),
        .d_i   (main_d_s),
        .q_o   (main_q)
    );

    pipe_entry_reg #(.W(EW), .CLR_W(CTRL_W)) u_skid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ld_i  (skid_ld_s),
        .clr_i (clr_s),
        .d_i   (in_bus_s),
        .q_o   (skid_q)
    );

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign ctrl_o      = out_valid_q ? main_q[CTRL_W-1:0] : {CTRL_W{1'b0}};
    assign data_o      = main_q[CTRL_W +: DW];
    assign addr_o      = main_q[CTRL_W+DW +: AW];

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Free-running wrap-around statistics; flush does not clear them
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q  <= (out_valid_q && !out_ready_i) ? stall_cnt_q + 32'd1 : stall_cnt_q;
            bubble_cnt_q <= (!out_valid_q) ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
